// File: rtl/shot_fire_ctrl_if.sv
// Launch handshake between the fire controller and the player shot block.
// The controller (master) drives the launch request and muzzle position.
// The shot block (slave) answers with its in-flight flag.
interface shot_fire_ctrl_if;
    logic        en;
    logic [10:0] orig_x;
    logic [10:0] orig_y;
    logic        shot_active;

    modport master (
        output en,
        output orig_x,
        output orig_y,
        input  shot_active
    );

    modport slave (
        input  en,
        input  orig_x,
        input  orig_y,
        output shot_active
    );
endinterface

// File: rtl/shot_fire_ctrl.sv
// shot_fire_ctrl: launcher for the player shot block.
// Synchronises and debounces the fire button and turns a debounced press
// into one launch request with a centred muzzle position. It holds en until
// the shot block acknowledges with shot_active, then enforces a reload
// cooldown before the next launch.
// Optional build macro SHOT_AUTO_FIRE_EN: while the debounced button is held
// high, the controller relaunches every time it returns to IDLE. Without the
// macro, only debounced rising edges launch.
module shot_fire_ctrl #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int COOLDOWN_TICKS = 30,
    parameter int FIRE_TIMEOUT   = 8,
    parameter int SHIP_WIDTH     = 32,
    parameter int SHOT_WIDTH     = 4
) (
    input  logic             clk_0,
    input  logic             rst_n,
    input  logic             fire_btn,
    input  logic             game_run,
    input  logic [10:0]      ship_x,
    input  logic [10:0]      ship_y,
    output logic             ready,
    output logic [15:0]      shots_fired,
    shot_fire_ctrl_if.master shot_if
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);
    localparam int TO_W = $clog2(FIRE_TIMEOUT + 1);
    localparam logic [11:0] X_OFFSET = 12'((SHIP_WIDTH - SHOT_WIDTH) / 2);
    localparam logic [11:0] X_MAX    = 12'd2047;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        FLIGHT,
        COOLDOWN
    } state_t;

    state_t            state;
    logic              fire_meta;
    logic              fire_sync;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic              db_rise;
    logic              req;
    logic [TO_W-1:0]   to_cnt;
    logic [CD_W-1:0]   cd_cnt;
    logic              en_q;
    logic [10:0]       orig_x_q;
    logic [10:0]       orig_y_q;
    logic [15:0]       shots_q;
    logic              want_fire;
    logic [11:0]       x_sum;
    logic [10:0]       x_launch;

`ifdef SHOT_AUTO_FIRE_EN
    assign want_fire = req | db_level;
`else
    assign want_fire = req;
`endif

    // Muzzle x is the ship left edge plus the centring offset, clamped to screen.
    assign x_sum    = {1'b0, ship_x} + X_OFFSET;
    assign x_launch = (x_sum > X_MAX) ? 11'h7FF : x_sum[10:0];

    assign ready          = (state == IDLE) && game_run && !shot_if.shot_active;
    assign shots_fired    = shots_q;
    assign shot_if.en     = en_q;
    assign shot_if.orig_x = orig_x_q;
    assign shot_if.orig_y = orig_y_q;

    // Two-flop synchroniser bringing the raw button into the tick domain.
    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            fire_meta <= 1'b0;
            fire_sync <= 1'b0;
        end else begin
            fire_meta <= fire_btn;
            fire_sync <= fire_meta;
        end
    end

    // Debouncer: level flips after enough consecutive differing samples; db_rise pulses on a 0->1 flip.
    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            db_rise  <= 1'b0;
        end else if (fire_sync == db_level) begin
            db_cnt  <= '0;
            db_rise <= 1'b0;
        end else if (db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
            db_level <= fire_sync;
            db_cnt   <= '0;
            db_rise  <= fire_sync;
        end else begin
            db_cnt  <= db_cnt + DB_W'(1);
            db_rise <= 1'b0;
        end
    end

    // Launch FSM: pending request, launch handshake, flight tracking and reload cooldown.
    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            en_q     <= 1'b0;
            to_cnt   <= '0;
            cd_cnt   <= '0;
            orig_x_q <= '0;
            orig_y_q <= '0;
            shots_q  <= '0;
        end else if (!game_run) begin
            state  <= IDLE;
            req    <= 1'b0;
            en_q   <= 1'b0;
            to_cnt <= '0;
            cd_cnt <= '0;
        end else begin
            if (db_rise && (state == IDLE)) begin
                req <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (want_fire && !shot_if.shot_active) begin
                        state    <= WAIT_ACK;
                        en_q     <= 1'b1;
                        req      <= 1'b0;
                        to_cnt   <= '0;
                        shots_q  <= shots_q + 16'd1;
                        orig_x_q <= x_launch;
                        orig_y_q <= ship_y;
                    end
                end
                WAIT_ACK: begin
                    if (shot_if.shot_active) begin
                        en_q   <= 1'b0;
                        to_cnt <= '0;
                        state  <= FLIGHT;
                    end else if (to_cnt == TO_W'(FIRE_TIMEOUT - 1)) begin
                        en_q   <= 1'b0;
                        to_cnt <= '0;
                        cd_cnt <= CD_W'(COOLDOWN_TICKS);
                        state  <= COOLDOWN;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                FLIGHT: begin
                    if (!shot_if.shot_active) begin
                        cd_cnt <= CD_W'(COOLDOWN_TICKS);
                        state  <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - CD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_fire_ctrl.sv
// Testbench for shot_fire_ctrl: directed launch/timeout/clamp/reset steps
// followed by randomized button, run and shot-block activity, all checked
// every tick against a time-stamp based reference model. The model honours
// SHOT_AUTO_FIRE_EN when the build defines it.
module tb_shot_fire_ctrl;

    localparam int DEBOUNCE_TICKS = 4;
    localparam int COOLDOWN_TICKS = 30;
    localparam int FIRE_TIMEOUT   = 8;
    localparam int SHIP_WIDTH     = 32;
    localparam int SHOT_WIDTH     = 4;

    localparam int PH_READY  = 0;
    localparam int PH_ASKING = 1;
    localparam int PH_AIR    = 2;
    localparam int PH_RELOAD = 3;

    logic        clk_0 = 1'b0;
    logic        rst_n;
    logic        fire_btn;
    logic        game_run;
    logic [10:0] ship_x;
    logic [10:0] ship_y;
    logic        shot_active;
    logic        ready;
    logic [15:0] shots_fired;

    shot_fire_ctrl_if shot_if ();
    assign shot_if.shot_active = shot_active;

    shot_fire_ctrl #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .COOLDOWN_TICKS (COOLDOWN_TICKS),
        .FIRE_TIMEOUT   (FIRE_TIMEOUT),
        .SHIP_WIDTH     (SHIP_WIDTH),
        .SHOT_WIDTH     (SHOT_WIDTH)
    ) dut (
        .clk_0       (clk_0),
        .rst_n       (rst_n),
        .fire_btn    (fire_btn),
        .game_run    (game_run),
        .ship_x      (ship_x),
        .ship_y      (ship_y),
        .ready       (ready),
        .shots_fired (shots_fired),
        .shot_if     (shot_if)
    );

    // Free-running game tick.
    always #5 clk_0 = ~clk_0;

    int total = 0;
    int bad   = 0;

    int m_tick;
    int raw_q[$];
    int sync_q[$];
    bit m_level;
    int m_last_flip;
    int m_rise_edge;
    bit m_req;
    int m_phase;
    int m_launch_edge;
    int m_idle_edge;
    bit m_en;
    int m_ox;
    int m_oy;
    int m_shots;

    function automatic void modelReset();
        m_tick        = 0;
        raw_q.delete();
        sync_q.delete();
        m_level       = 1'b0;
        m_last_flip   = 0;
        m_rise_edge   = -10;
        m_req         = 1'b0;
        m_phase       = PH_READY;
        m_launch_edge = 0;
        m_idle_edge   = 0;
        m_en          = 1'b0;
        m_ox          = 0;
        m_oy          = 0;
        m_shots       = 0;
    endfunction

    function automatic void modelStep();
        int e;
        int synced;
        bit level_p;
        bit req_p;
        bit want;
        bit flip;
        int phase_p;
        m_tick++;
        e = m_tick;
        raw_q.push_back(int'(fire_btn));
        synced = (e >= 3) ? raw_q[e-3] : 0;
        sync_q.push_back(synced);
        level_p = m_level;
        req_p   = m_req;
        phase_p = m_phase;
        flip = 1'b1;
        for (int j = 0; j < DEBOUNCE_TICKS; j++) begin
            if ((e - j) <= m_last_flip || (e - j) < 1) flip = 1'b0;
            else if (sync_q[e-j-1] == int'(level_p)) flip = 1'b0;
        end
        if (flip) begin
            m_level     = !level_p;
            m_last_flip = e;
            if (!level_p) m_rise_edge = e;
        end
        want = req_p;
`ifdef SHOT_AUTO_FIRE_EN
        want = req_p || level_p;
`endif
        if (!game_run) begin
            m_phase = PH_READY;
            m_en    = 1'b0;
            m_req   = 1'b0;
        end else begin
            if (m_rise_edge == e - 1 && phase_p == PH_READY) m_req = 1'b1;
            case (phase_p)
                PH_READY: if (want && !shot_active) begin
                    m_phase       = PH_ASKING;
                    m_en          = 1'b1;
                    m_req         = 1'b0;
                    m_launch_edge = e;
                    m_shots       = (m_shots + 1) % 65536;
                    m_ox          = int'(ship_x) + (SHIP_WIDTH - SHOT_WIDTH) / 2;
                    if (m_ox > 2047) m_ox = 2047;
                    m_oy          = int'(ship_y);
                end
                PH_ASKING: if (shot_active) begin
                    m_en    = 1'b0;
                    m_phase = PH_AIR;
                end else if (e - m_launch_edge == FIRE_TIMEOUT) begin
                    m_en        = 1'b0;
                    m_phase     = PH_RELOAD;
                    m_idle_edge = e + COOLDOWN_TICKS + 1;
                end
                PH_AIR: if (!shot_active) begin
                    m_phase     = PH_RELOAD;
                    m_idle_edge = e + COOLDOWN_TICKS + 1;
                end
                default: if (e == m_idle_edge) m_phase = PH_READY;
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk_0);
            modelStep();
            @(negedge clk_0);
            checkOutput("en", 16'(shot_if.en), 16'(m_en));
            checkOutput("orig_x", 16'(shot_if.orig_x), 16'(m_ox));
            checkOutput("orig_y", 16'(shot_if.orig_y), 16'(m_oy));
            checkOutput("shots_fired", shots_fired, 16'(m_shots));
            checkOutput("ready", 16'(ready), 16'(m_phase == PH_READY && game_run && !shot_active));
        end
    endtask

    // Directed steps, then randomized traffic, then the summary.
    initial begin
        rst_n       = 1'b0;
        fire_btn    = 1'b0;
        game_run    = 1'b1;
        shot_active = 1'b0;
        ship_x      = 11'd100;
        ship_y      = 11'd440;
        modelReset();
        repeat (3) @(negedge clk_0);
        rst_n = 1'b1;
        $display("[TB] reset released");
        checkOutput("rst_en", 16'(shot_if.en), 16'd0);
        checkOutput("rst_orig_x", 16'(shot_if.orig_x), 16'd0);
        checkOutput("rst_orig_y", 16'(shot_if.orig_y), 16'd0);
        checkOutput("rst_shots", shots_fired, 16'd0);
        checkOutput("rst_ready", 16'(ready), 16'd1);

        fire_btn = 1'b1;
        applyStimulus(3);
        fire_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            checkOutput("glitch_en", 16'(shot_if.en), 16'd0);
        end
        checkOutput("glitch_shots", shots_fired, 16'd0);

        fire_btn = 1'b1;
        applyStimulus(7);
        checkOutput("lat_en_k6", 16'(shot_if.en), 16'd0);
        applyStimulus(1);
        checkOutput("lat_en_k7", 16'(shot_if.en), 16'd1);
        checkOutput("launch_orig_x", 16'(shot_if.orig_x), 16'd114);
        checkOutput("launch_orig_y", 16'(shot_if.orig_y), 16'd440);
        checkOutput("launch_shots", shots_fired, 16'd1);
        shot_active = 1'b1;
        applyStimulus(1);
        checkOutput("ack_en", 16'(shot_if.en), 16'd0);

        fire_btn = 1'b0;
        applyStimulus(8);
        fire_btn = 1'b1;
        applyStimulus(10);
        checkOutput("flight_press_en", 16'(shot_if.en), 16'd0);
        checkOutput("flight_press_shots", shots_fired, 16'd1);
        fire_btn = 1'b0;
        applyStimulus(8);

        shot_active = 1'b0;
        applyStimulus(31);
        checkOutput("cool_ready_m30", 16'(ready), 16'd0);
        applyStimulus(1);
        checkOutput("cool_ready_m31", 16'(ready), 16'd1);

        fire_btn = 1'b1;
        applyStimulus(8);
        checkOutput("second_en", 16'(shot_if.en), 16'd1);
        checkOutput("second_shots", shots_fired, 16'd2);
        applyStimulus(7);
        checkOutput("timeout_en_hold", 16'(shot_if.en), 16'd1);
        applyStimulus(1);
        checkOutput("timeout_en_drop", 16'(shot_if.en), 16'd0);
        checkOutput("timeout_shots", shots_fired, 16'd2);
        checkOutput("timeout_ready", 16'(ready), 16'd0);
        fire_btn = 1'b0;
        applyStimulus(31);
        checkOutput("timeout_cool_done", 16'(ready), 16'd1);

        ship_x   = 11'd2040;
        ship_y   = 11'd17;
        fire_btn = 1'b1;
        applyStimulus(8);
        checkOutput("clamp_en", 16'(shot_if.en), 16'd1);
        checkOutput("clamp_orig_x", 16'(shot_if.orig_x), 16'd2047);
        checkOutput("clamp_orig_y", 16'(shot_if.orig_y), 16'd17);
        checkOutput("clamp_shots", shots_fired, 16'd3);

        game_run = 1'b0;
        applyStimulus(1);
        checkOutput("run_drop_en", 16'(shot_if.en), 16'd0);
        checkOutput("run_drop_ready", 16'(ready), 16'd0);
        fire_btn = 1'b0;
        applyStimulus(8);
        game_run = 1'b1;
        applyStimulus(1);
        checkOutput("run_back_ready", 16'(ready), 16'd1);
        checkOutput("run_back_shots", shots_fired, 16'd3);

        fire_btn = 1'b1;
        applyStimulus(8);
        checkOutput("pre_reset_en", 16'(shot_if.en), 16'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_en", 16'(shot_if.en), 16'd0);
        checkOutput("async_rst_shots", shots_fired, 16'd0);
        checkOutput("async_rst_orig_x", 16'(shot_if.orig_x), 16'd0);
        modelReset();
        fire_btn = 1'b0;
        @(negedge clk_0);
        rst_n = 1'b1;

        $display("[TB] starting randomized traffic");
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) fire_btn = ~fire_btn;
            game_run = ($urandom_range(0, 59) != 0);
            if (m_en) shot_active = ($urandom_range(0, 9) < 7);
            else if (shot_active) shot_active = ($urandom_range(0, 4) != 0);
            else shot_active = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) begin
                ship_x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2020, 2047)) : 11'($urandom);
                ship_y = 11'($urandom);
            end
            applyStimulus(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
